// File: rtl/eval_scoreboard_if.sv
// Result/readout/status bundle for eval_scoreboard.
// master drives results and readout requests; slave returns readouts and run status.
interface eval_scoreboard_if #(
    parameter int unsigned CW = 8
);
    logic          res_valid;
    logic [7:0]    res_class;
    logic [7:0]    res_label;
    logic          rd_req;
    logic [7:0]    rd_class;
    logic          rd_valid;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] total;
    logic [CW-1:0] correct;
    logic          done;
    logic          err_range;

    modport master (
        output res_valid, res_class, res_label, rd_req, rd_class,
        input  rd_valid, rd_count, total, correct, done, err_range
    );

    modport slave (
        input  res_valid, res_class, res_label, rd_req, rd_class,
        output rd_valid, rd_count, total, correct, done, err_range
    );
endinterface

// File: rtl/eval_scoreboard.sv
// Classifier evaluation scoreboard: counts results, correct hits and per-class hits over a run.
// Define SCOREBOARD_PERCLASS_EN to build the per-class counters and their readout path.
module eval_scoreboard #(
    parameter int unsigned NCLASS = 10,
    parameter int unsigned NSAMP  = 100,
    parameter int unsigned CW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    eval_scoreboard_if.slave bus
);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic {ST_RUN = 1'b0, ST_DONE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] total_q, total_d;
    logic [CW-1:0] correct_q, correct_d;
    logic          err_q, err_d;
    logic          done_q;
    logic          rd_valid_q;
    logic [CW-1:0] rd_count_q;
    logic          take, in_range, hit;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + CW'(1);
    endfunction

    // A sample is accepted only while running and not overridden by clr
    assign take     = (state_q == ST_RUN) && bus.res_valid && !clr;
    assign in_range = 32'(bus.res_label) < NCLASS;
    assign hit      = take && in_range && (bus.res_class == bus.res_label);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr)                                 state_d = ST_RUN;
        else if (take && 32'(total_d) == NSAMP)  state_d = ST_DONE;
    end

    always_comb begin
        total_d   = total_q;
        correct_d = correct_q;
        err_d     = err_q;
        if (clr) begin
            total_d   = '0;
            correct_d = '0;
            err_d     = 1'b0;
        end else if (take) begin
            total_d = sat_inc(total_q);
            if (hit)       correct_d = sat_inc(correct_q);
            if (!in_range) err_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q    <= '0;
            correct_q  <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            total_q    <= total_d;
            correct_q  <= correct_d;
            err_q      <= err_d;
            done_q     <= (state_d == ST_DONE);
            rd_valid_q <= bus.rd_req;
        end
    end

`ifdef SCOREBOARD_PERCLASS_EN
    localparam int unsigned IW = (NCLASS > 1) ? $clog2(NCLASS) : 1;

    logic [CW-1:0] cls_q [NCLASS];

    // Readout samples the registered counters, so a coincident update is not yet visible
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NCLASS); i++) cls_q[i] <= '0;
            rd_count_q <= '0;
        end else begin
            for (int i = 0; i < int'(NCLASS); i++) begin
                if (clr)                                    cls_q[i] <= '0;
                else if (hit && bus.res_label == 8'(i))     cls_q[i] <= sat_inc(cls_q[i]);
            end
            if (bus.rd_req)
                rd_count_q <= (32'(bus.rd_class) < NCLASS) ? cls_q[IW'(bus.rd_class)] : '0;
        end
    end
`else
    logic [7:0] unused_rd_class;
    assign unused_rd_class = bus.rd_class;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_count_q <= '0;
        else      rd_count_q <= '0;
    end
`endif

    assign bus.total     = total_q;
    assign bus.correct   = correct_q;
    assign bus.done      = done_q;
    assign bus.err_range = err_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_count  = rd_count_q;
endmodule

// File: tb/tb_eval_scoreboard.sv
// Self-checking bench for eval_scoreboard: vector table, hand sequences and a random run
// against a transaction-level model of the scoring rules.
module tb_eval_scoreboard;
    localparam int NCLASS = 10;
    localparam int NSAMP  = 100;
    localparam int CW     = 8;
    localparam int CW4    = 4;
    localparam int MAXV   = (1 << CW) - 1;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic clr  = 1'b0;
    logic clr4 = 1'b0;

    always #5 clk = ~clk;

    eval_scoreboard_if #(.CW(CW))  sb ();
    eval_scoreboard_if #(.CW(CW4)) sb4 ();

    eval_scoreboard #(.NCLASS(NCLASS), .NSAMP(NSAMP), .CW(CW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(sb)
    );
    eval_scoreboard #(.NCLASS(NCLASS), .NSAMP(NSAMP), .CW(CW4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr4), .bus(sb4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: counts kept as plain integers, saturated at the counter maximum
    int m_total, m_correct, m_rdc;
    int m_cls [NCLASS];
    bit m_done, m_err, m_rdv;

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    function automatic int lookup(input int c);
`ifdef SCOREBOARD_PERCLASS_EN
        return (c >= 0 && c < NCLASS) ? m_cls[c] : 0;
`else
        return 0;
`endif
    endfunction

    function automatic void m_clear();
        m_total = 0; m_correct = 0; m_done = 0; m_err = 0;
        for (int i = 0; i < NCLASS; i++) m_cls[i] = 0;
    endfunction

    function automatic void m_reset();
        m_clear();
        m_rdv = 0; m_rdc = 0;
    endfunction

    function automatic void m_step(input bit c, input bit v, input int cls, input int lab,
                                   input bit rq, input int rc);
        m_rdv = rq;
        if (rq) m_rdc = lookup(rc);
        if (c) m_clear();
        else if (v && !m_done) begin
            m_total = sat(m_total + 1);
            if (lab >= NCLASS) m_err = 1;
            else if (cls == lab) begin
                m_correct   = sat(m_correct + 1);
                m_cls[lab]  = sat(m_cls[lab] + 1);
            end
            if (m_total == NSAMP) m_done = 1;
        end
    endfunction

    task automatic cycle(input bit c, input bit v, input int cls, input int lab,
                         input bit rq, input int rc);
        clr = c; sb.res_valid = v; sb.res_class = 8'(cls); sb.res_label = 8'(lab);
        sb.rd_req = rq; sb.rd_class = 8'(rc);
        @(posedge clk);
        m_step(c, v, cls, lab, rq, rc);
        @(negedge clk);
        clr = 1'b0; sb.res_valid = 1'b0; sb.rd_req = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".total"},     int'(sb.total),     m_total);
        chk({tag, ".correct"},   int'(sb.correct),   m_correct);
        chk({tag, ".done"},      int'(sb.done),      int'(m_done));
        chk({tag, ".err_range"}, int'(sb.err_range), int'(m_err));
        chk({tag, ".rd_valid"},  int'(sb.rd_valid),  int'(m_rdv));
        chk({tag, ".rd_count"},  int'(sb.rd_count),  m_rdc);
    endtask

    typedef struct {
        bit c; bit v; int cls; int lab; bit rq; int rc;
        int e_total; int e_correct; bit e_done; bit e_err; int e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit c, input bit v, input int cls, input int lab,
                                input bit rq, input int rc, input int et, input int ec,
                                input bit ed, input bit ee, input int er);
        vec_t r;
        r.c = c; r.v = v; r.cls = cls; r.lab = lab; r.rq = rq; r.rc = rc;
        r.e_total = et; r.e_correct = ec; r.e_done = ed; r.e_err = ee; r.e_rd = er;
        return r;
    endfunction

    initial begin
        int lab, cls, exp_rd;
        bit perclass;
`ifdef SCOREBOARD_PERCLASS_EN
        perclass = 1'b1;
`else
        perclass = 1'b0;
`endif
        sb.res_valid = 0; sb.res_class = 0; sb.res_label = 0; sb.rd_req = 0; sb.rd_class = 0;
        sb4.res_valid = 0; sb4.res_class = 0; sb4.res_label = 0; sb4.rd_req = 0; sb4.rd_class = 0;
        m_reset();

        for (int k = 1; k <= 10; k++) tbl.push_back(mk(0, 1, 3, 3, 0, 0, k, k, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3,   10, 10, 0, 0, 10));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4,   10, 10, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 3, 1, 3,   11, 11, 0, 0, 10));
        tbl.push_back(mk(0, 0, 0, 0, 1, 200, 11, 11, 0, 0, 0));
        tbl.push_back(mk(0, 1, 12, 12, 0, 0, 12, 11, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5, 4, 1, 3,  13, 11, 0, 1, 11));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 3, 3, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 7, 1, 3,   1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7,   1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 12, 12, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.total",    int'(sb.total),    0);
        chk("reset.correct",  int'(sb.correct),  0);
        chk("reset.done",     int'(sb.done),     0);
        chk("reset.err",      int'(sb.err_range), 0);
        chk("reset.rd_valid", int'(sb.rd_valid), 0);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            cycle(tbl[i].c, tbl[i].v, tbl[i].cls, tbl[i].lab, tbl[i].rq, tbl[i].rc);
            chk($sformatf("vec%0d.total", i),    int'(sb.total),     tbl[i].e_total);
            chk($sformatf("vec%0d.correct", i),  int'(sb.correct),   tbl[i].e_correct);
            chk($sformatf("vec%0d.done", i),     int'(sb.done),      int'(tbl[i].e_done));
            chk($sformatf("vec%0d.err", i),      int'(sb.err_range), int'(tbl[i].e_err));
            chk($sformatf("vec%0d.rd_valid", i), int'(sb.rd_valid),  int'(tbl[i].rq));
            if (tbl[i].rq) begin
                exp_rd = perclass ? tbl[i].e_rd : 0;
                chk($sformatf("vec%0d.rd_count", i), int'(sb.rd_count), exp_rd);
            end
        end

        // Full run of NSAMP samples, every 10th misclassified
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < NSAMP; i++) begin
            lab = int'($urandom_range(0, NCLASS - 1));
            cls = (i % 10 == 9) ? (lab + 1) % NCLASS : lab;
            cycle(0, 1, cls, lab, 0, 0);
            if (i == NSAMP - 2) chk("run.done_early", int'(sb.done), 0);
        end
        chk("run.total",   int'(sb.total),   100);
        chk("run.correct", int'(sb.correct), 90);
        chk("run.done",    int'(sb.done),    1);
        check_model("run.model");
        cycle(0, 1, 2, 2, 0, 0);
        chk("run.extra_total",   int'(sb.total),   100);
        chk("run.extra_correct", int'(sb.correct), 90);
        chk("run.extra_done",    int'(sb.done),    1);
        for (int c = 0; c < NCLASS; c++) begin
            cycle(0, 0, 0, 0, 1, c);
            check_model($sformatf("done_rd%0d", c));
        end

        // Saturating counters on the narrow instance
        clr4 = 1'b1; @(posedge clk); @(negedge clk); clr4 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            sb4.res_valid = 1; sb4.res_class = 8'(0); sb4.res_label = 8'(0);
            @(posedge clk); @(negedge clk);
            sb4.res_valid = 0;
            if (i == 15) chk("sat.total15", int'(sb4.total), 15);
        end
        chk("sat.total",   int'(sb4.total),   15);
        chk("sat.correct", int'(sb4.correct), 15);
        chk("sat.done",    int'(sb4.done),    0);
        sb4.rd_req = 1; sb4.rd_class = 8'(0);
        @(posedge clk); @(negedge clk);
        sb4.rd_req = 0;
        chk("sat.rd_valid", int'(sb4.rd_valid), 1);
        chk("sat.rd_count", int'(sb4.rd_count), perclass ? 15 : 0);

        // Randomised run against the model
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            bit c, v, rq;
            int rc;
            c   = ($urandom_range(0, 299) == 0);
            v   = 1'($urandom_range(0, 1));
            lab = int'($urandom_range(0, 12));
            cls = ($urandom_range(0, 1) == 1) ? lab : int'($urandom_range(0, 12));
            rq  = ($urandom_range(0, 2) == 0);
            rc  = int'($urandom_range(0, 11));
            cycle(c, v, cls, lab, rq, rc);
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-run, with a sample pending in the same cycle
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 3, 3, 0, 0);
        chk("rst.pre_total", int'(sb.total), 5);
        sb.res_valid = 1; sb.res_class = 8'(3); sb.res_label = 8'(3); sb.rd_req = 1; sb.rd_class = 8'(3);
        #2 rst = 1'b0;
        #1;
        chk("rst.total",    int'(sb.total),     0);
        chk("rst.correct",  int'(sb.correct),   0);
        chk("rst.done",     int'(sb.done),      0);
        chk("rst.err",      int'(sb.err_range), 0);
        chk("rst.rd_valid", int'(sb.rd_valid),  0);
        chk("rst.rd_count", int'(sb.rd_count),  0);
        chk("rst.total4",   int'(sb4.total),    0);
        m_reset();
        @(posedge clk); #1;
        chk("rst.hold_total",    int'(sb.total),    0);
        chk("rst.hold_rd_valid", int'(sb.rd_valid), 0);
        @(negedge clk);
        sb.res_valid = 0; sb.rd_req = 0;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(0, 1, 6, 6, 0, 0);
        check_model("rst.restart");
        chk("rst.restart_total", int'(sb.total), 3);
        for (int c = 0; c < NCLASS; c++) begin
            cycle(0, 0, 0, 0, 1, c);
            check_model($sformatf("rst_rd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eval_scoreboard.md
EVAL_SCOREBOARD -- requirements
Module: eval_scoreboard

Interface
REQ-001 The parameter NCLASS SHALL default to 10 and set the number of class labels, 0..NCLASS-1.
REQ-002 The parameter NSAMP SHALL default to 100 and set the number of samples per evaluation run.
REQ-003 The parameter CW SHALL default to 8 and set the width of every counter.
REQ-004 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-005 The port rst SHALL be an input, 1 bit wide, and be an asynchronous, active-low reset.
REQ-006 The port clr SHALL be an input, 1 bit wide, and be a synchronous clear that starts a new run.
REQ-007 The port res_valid SHALL be an input, 1 bit wide, and be a one-cycle pulse marking a finished classification (the classifier's finished strobe).
REQ-008 The port res_class SHALL be an input, 8 bits wide, and carry the classifier's predicted class, sampled when res_valid=1.
REQ-009 The port res_label SHALL be an input, 8 bits wide, and carry the expected class (sample number) for the same result.
REQ-010 The ports rd_req (input, 1 bit) and rd_class (input, 8 bits) SHALL request a readout of one class's counter.
REQ-011 The ports rd_valid (output, 1 bit) and rd_count (output, CW bits) SHALL return the readout response.
REQ-012 The outputs total, correct (each CW bits) and done, err_range (each 1 bit) SHALL report the run status.

Function
REQ-013 Every output SHALL be a register.
REQ-014 The block SHALL have two states: RUN and DONE.
REQ-015 In RUN, a cycle with res_valid=1 SHALL increment total by 1.
REQ-016 In RUN, if res_valid=1 and res_class==res_label and res_label<NCLASS, correct SHALL increment by 1 and the per-class counter of res_label SHALL increment by 1.
REQ-017 Every counter update SHALL be visible on the cycle after the res_valid edge.
REQ-018 If res_valid=1 and res_label>=NCLASS, the sample SHALL count in total but not in correct, and err_range SHALL set and remain set until clr or reset.
REQ-019 When the update takes total to NSAMP, the state SHALL move to DONE and done SHALL rise in the same cycle that total shows NSAMP.
REQ-020 In DONE, res_valid SHALL be ignored, all counters SHALL hold, and done SHALL stay 1.
REQ-021 All counters SHALL saturate at 2^CW-1 and never wrap.
REQ-022 clr=1 SHALL zero all counters, done and err_range, and enter RUN, from either state.
REQ-023 If clr and res_valid are high in the same cycle, clr SHALL win and the sample SHALL be discarded.
REQ-024 rd_req=1 SHALL produce rd_valid=1 for exactly one cycle, one cycle later.
REQ-025 The readout SHALL return rd_count equal to the per-class counter of rd_class, or 0 if rd_class>=NCLASS.
REQ-026 A readout SHALL return the pre-update value when it coincides with an update to the same class.
REQ-027 Readout SHALL be allowed in both RUN and DONE.

Reset
REQ-028 While rst=0, asynchronously: state=RUN; total, correct, rd_count and all per-class counters =0; done, err_range, rd_valid =0.
REQ-029 Reset asserted mid-run SHALL discard all accumulated results; no partial update from the cycle of reset assertion SHALL survive.

Configuration
REQ-030 With macro SCOREBOARD_PERCLASS_EN defined, the NCLASS per-class counters and the readout path of REQ-024..REQ-027 SHALL be implemented.
REQ-031 Without SCOREBOARD_PERCLASS_EN, no per-class counters SHALL be built, rd_valid SHALL still pulse per REQ-024, and rd_count SHALL read constant 0; total, correct, done and err_range are unaffected.

Verification
REQ-032 Scenario: reset, then 10 pulses with res_class=res_label=3 -> total=10, correct=10; readout of class 3 returns 10; readout of class 4 returns 0.
REQ-033 Scenario: NSAMP=100 with 100 pulses, each res_class=label except every 10th -> done rises on the 100th update with total=100, correct=90; a 101st pulse leaves both unchanged.
REQ-034 Scenario: one pulse with res_label=12 and res_class=12 -> total=1, correct=0, err_range=1; clr -> err_range=0, total=0.
REQ-035 Scenario: clr and res_valid in the same cycle -> total=0 on the next cycle.
REQ-036 Scenario: CW=4, 20 matching pulses on class 0 with NSAMP=100 -> total=15, correct=15 (saturated), done=0.
REQ-037 Scenario: rst pulsed low mid-run after 5 samples -> all outputs 0 immediately (asynchronous), counting restarts from 0; with the macro undefined, rd_count=0 for every class.
